// File: rtl/svc_rv_mem_model_if.sv
// Bus between an svc_rv core port (imem/dmem) and svc_rv_mem_model.
// The bench or core drives the master side; the memory model is the slave.
interface svc_rv_mem_model_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 2
);
  // Handshake: ren/we are requests. A request is accepted on any cycle where
  // it is high and stall is low. While stall is high, the master holds the
  // request and its address/data stable and presents them again. resp_valid
  // marks the rdata of an accepted read.
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          resp_valid;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          stall_req;
  logic          stall;
  logic [CW-1:0] stall_count;

  modport master (
    output ren, raddr, we, waddr, wdata, wstrb, stall_req,
    input  rdata, resp_valid, stall, stall_count
  );

  modport slave (
    input  ren, raddr, we, waddr, wdata, wstrb, stall_req,
    output rdata, resp_valid, stall, stall_count
  );
endinterface

// File: rtl/svc_rv_mem_model.sv
// Memory responder for svc_rv cores with byte-strobe writes, 0/1-cycle reads and
// bounded stall injection (enabled by defining SVC_RV_MEM_MODEL_STALL_EN).
module svc_rv_mem_model #(
  parameter int             AW          = 32,
  parameter int             DW          = 32,
  parameter int             DEPTH_WORDS = 32,
  parameter int             LATENCY     = 1,
  parameter int             MAX_STALL   = 2,
  parameter logic [DW-1:0]  INIT_WORD   = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  svc_rv_mem_model_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_STALL + 1);

  logic [DW-1:0] mem_q [DEPTH_WORDS];
  logic [IW-1:0] ridx;
  logic [IW-1:0] widx;
  logic [DW-1:0] rd_word;
  logic          pending;
  logic          active;
  logic          stall;
  logic          rd_accept;
  logic          wr_accept;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH_WORDS*4.
  assign ridx      = bus.raddr[IW+1:2];
  assign widx      = bus.waddr[IW+1:2];
  assign rd_word   = mem_q[ridx];
  assign active    = bus.ren || bus.we || pending;
  assign rd_accept = bus.ren && !stall;
  assign wr_accept = bus.we && !stall && !reset;

  logic unused_addr;
  assign unused_addr = ^{bus.raddr[AW-1:IW+2], bus.raddr[1:0],
                         bus.waddr[AW-1:IW+2], bus.waddr[1:0]};

`ifdef SVC_RV_MEM_MODEL_STALL_EN
  logic [CW-1:0] stall_count_q;
  logic [CW-1:0] stall_count_d;

  // Stall is granted only while the consecutive count is below MAX_STALL, which
  // forces at least one non-stall cycle after every MAX_STALL-long burst.
  always_comb begin
    stall         = 1'b0;
    stall_count_d = '0;
    if (!reset && bus.stall_req && active && (stall_count_q < CW'(MAX_STALL)))
      stall = 1'b1;
    if (stall)
      stall_count_d = stall_count_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign bus.stall_count = stall_count_q;
`else
  assign stall           = 1'b0;
  assign bus.stall_count = '0;

  logic unused_stall;
  assign unused_stall = ^{bus.stall_req, active};
`endif

  assign bus.stall = stall;

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem_q[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  if (LATENCY == 0) begin : g_comb_read
    assign pending        = 1'b0;
    assign bus.rdata      = bus.ren ? rd_word : '0;
    assign bus.resp_valid = rd_accept;
  end else begin : g_reg_read
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          resp_valid_q;
    logic          resp_valid_d;

    // rd_word is sampled before this edge's write lands: read-first.
    always_comb begin
      rdata_d      = rdata_q;
      resp_valid_d = rd_accept;
      if (rd_accept) rdata_d = rd_word;
      if (reset) begin
        rdata_d      = INIT_WORD;
        resp_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clock) begin
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
    end

    assign pending        = resp_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
  end
endmodule

// File: tb/tb_svc_rv_mem_model.sv
// Bench for svc_rv_mem_model: a LATENCY=0 and a LATENCY=1 instance share one
// stimulus stream and are each compared against a behavioural memory model.
module tb_svc_rv_mem_model;
  localparam int DEPTH = 32;
  localparam int MAXS  = 2;
  localparam logic [31:0] INIT = 32'h00000013;
`ifdef SVC_RV_MEM_MODEL_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  logic        ren = 1'b0, we = 1'b0, stall_req = 1'b0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  svc_rv_mem_model_if #(.AW(32), .DW(32), .CW(2)) if0 ();
  svc_rv_mem_model_if #(.AW(32), .DW(32), .CW(2)) if1 ();

  assign if0.ren = ren;             assign if1.ren = ren;
  assign if0.raddr = raddr;         assign if1.raddr = raddr;
  assign if0.we = we;               assign if1.we = we;
  assign if0.waddr = waddr;         assign if1.waddr = waddr;
  assign if0.wdata = wdata;         assign if1.wdata = wdata;
  assign if0.wstrb = wstrb;         assign if1.wstrb = wstrb;
  assign if0.stall_req = stall_req; assign if1.stall_req = stall_req;

  svc_rv_mem_model #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTH), .LATENCY(0),
                     .MAX_STALL(MAXS), .INIT_WORD(INIT))
    dut0 (.clock(clock), .reset(reset), .bus(if0));
  svc_rv_mem_model #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTH), .LATENCY(1),
                     .MAX_STALL(MAXS), .INIT_WORD(INIT))
    dut1 (.clock(clock), .reset(reset), .bus(if1));

  // scoreboard counters
  int checks = 0;
  int errors = 0;
  bit do_check = 1'b0;

  // reference model state, index 0 = LATENCY 0, index 1 = LATENCY 1
  logic [31:0] mem_m [2][DEPTH];
  int          cnt_m [2];
  bit          pend_m [2];
  logic [31:0] rdreg_m [2];

  // last observed outputs
  logic [31:0] obs_rdata [2];
  logic        obs_rv [2];
  logic        obs_stall [2];
  logic [1:0]  obs_cnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'((a % (DEPTH * 4)) / 4);
  endfunction

  // one clock cycle: drive, compare outputs against the model, advance the model
  task automatic step(input bit rst, input bit r, input logic [31:0] ra,
                      input bit w, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit sr);
    bit          e_stall [2];
    logic [31:0] e_rdata, rd;
    bit          e_rv, act;
    @(negedge clock);
    reset = rst; ren = r; raddr = ra; we = w; waddr = wa; wdata = wd;
    wstrb = ws; stall_req = sr;
    #1;
    obs_rdata[0] = if0.rdata; obs_rv[0] = if0.resp_valid;
    obs_stall[0] = if0.stall; obs_cnt[0] = if0.stall_count;
    obs_rdata[1] = if1.rdata; obs_rv[1] = if1.resp_valid;
    obs_stall[1] = if1.stall; obs_cnt[1] = if1.stall_count;
    for (int k = 0; k < 2; k++) begin
      act = r || w || (k == 1 && pend_m[k]);
      e_stall[k] = STALL_EN && !rst && sr && act && (cnt_m[k] < MAXS);
      if (k == 0) begin
        e_rdata = r ? mem_m[0][idx(ra)] : 32'h0;
        e_rv    = r && !e_stall[0];
      end else begin
        e_rdata = rdreg_m[1];
        e_rv    = pend_m[1];
      end
      if (do_check) begin
        check($sformatf("l%0d_stall", k), 32'(obs_stall[k]), 32'(e_stall[k]));
        check($sformatf("l%0d_stall_count", k), 32'(obs_cnt[k]), 32'(cnt_m[k]));
        check($sformatf("l%0d_resp_valid", k), 32'(obs_rv[k]), 32'(e_rv));
        check($sformatf("l%0d_rdata", k), obs_rdata[k], e_rdata);
      end
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt_m[k] = 0; pend_m[k] = 1'b0; rdreg_m[k] = INIT;
      end else begin
        rd = mem_m[k][idx(ra)];
        cnt_m[k]  = e_stall[k] ? cnt_m[k] + 1 : 0;
        pend_m[k] = r && !e_stall[k];
        if (r && !e_stall[k]) rdreg_m[k] = rd;
        if (w && !e_stall[k])
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem_m[k][idx(wa)][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic idle(input bit sr);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, sr);
  endtask

  task automatic rd_op(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b0, 32'h0, 1'b1, a, d, s, 1'b0);
  endtask

  initial begin : stim
    bit exp_pat [6];
    exp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset held two cycles
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    do_check = 1'b1;
    idle(1'b0);
    check("reset_rdata", obs_rdata[1], INIT);
    check("reset_stall", 32'(obs_stall[1]), 32'h0);
    check("reset_resp_valid", 32'(obs_rv[1]), 32'h0);
    check("reset_stall_count", 32'(obs_cnt[1]), 32'h0);

    // give every word a known value
    for (int i = 0; i < DEPTH; i++) wr_op(32'(i * 4), $urandom, 4'hF);

    // byte-strobe merge
    wr_op(32'h08, 32'hDEADBEEF, 4'hF);
    wr_op(32'h08, 32'h0000AA00, 4'h2);
    rd_op(32'h08);
    check("strobe_l0_rdata", obs_rdata[0], 32'hDEADAAEF);
    idle(1'b0);
    check("strobe_l1_rdata", obs_rdata[1], 32'hDEADAAEF);
    check("strobe_l1_resp_valid", 32'(obs_rv[1]), 32'h1);

    // address wrap and ignored low bits
    wr_op(32'h80, 32'h12345678, 4'hF);
    rd_op(32'h00);
    check("wrap_l0_rdata", obs_rdata[0], 32'h12345678);
    rd_op(32'h03);
    check("wrap_l1_rdata", obs_rdata[1], 32'h12345678);
    check("wrap_l0_rdata_lowbits", obs_rdata[0], 32'h12345678);
    idle(1'b0);
    check("wrap_l1_rdata_lowbits", obs_rdata[1], 32'h12345678);

    // continuous stall request with continuous reads
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'(i * 4 + 4), 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      check($sformatf("stall_pattern_%0d", i), 32'(obs_stall[1]),
            32'(STALL_EN && exp_pat[i]));
    end

    // stall request with no activity is ignored
    idle(1'b0);
    idle(1'b1);
    check("idle_stall_a", 32'(obs_stall[1]), 32'h0);
    idle(1'b1);
    check("idle_stall_b", 32'(obs_stall[0]), 32'h0);

    // write re-presented across stall cycles, read-first on the same index
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1);
    idle(1'b0);
    rd_op(32'h40);
    idle(1'b0);
    check("stalled_write_l1", obs_rdata[1], 32'hCAFEF00D);

    // reset on the second stall cycle
    step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 32'h11111111, 4'hF, 1'b1);
    check("midstall_reset_stall", 32'(obs_stall[1]), 32'h0);
    idle(1'b0);
    check("midstall_reset_rdata", obs_rdata[1], INIT);
    check("midstall_reset_count", 32'(obs_cnt[1]), 32'h0);
    rd_op(32'h40);
    idle(1'b0);
    check("post_reset_data", obs_rdata[1], 32'hCAFEF00D);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), $urandom, 1'($urandom),
           $urandom, $urandom, 4'($urandom), 1'($urandom));
    end
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/svc_rv_mem_model.md
Name: svc_rv_mem_model

Overview:
Parametrised single-port-read / single-port-write memory responder for svc_rv cores, used as imem or dmem backing store in formal and simulation benches.
- Holds real storage with byte-strobe writes and address wrap-around.
- Read latency is selectable: 0-cycle SRAM style or 1-cycle BRAM style.
- Converts a free-running stall request into a bounded, protocol-legal stall with data hold.
- Sits between the core's imem_*/dmem_* ports and the bench, replacing ad-hoc per-wrapper timing/stall logic.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; must be 32.
- DEPTH_WORDS, 32, storage words; power of two, >= 2.
- LATENCY, 1, read latency: 0 = combinational, 1 = registered.
- MAX_STALL, 2, maximum consecutive stall cycles; >= 1.
- INIT_WORD, 32'h00000013, registered rdata value after reset (LATENCY=1 only).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ren  in  1  read request.
- raddr  in  AW  read byte address.
- rdata  out  DW  read data.
- resp_valid  out  1  LATENCY=1: registered read data updated this cycle; LATENCY=0: equals ren && !stall.
- we  in  1  write request.
- waddr  in  AW  write byte address.
- wdata  in  DW  write data.
- wstrb  in  4  byte-lane write enables.
- stall_req  in  1  unconstrained stall request (solver or bench).
- stall  out  1  effective, bounded stall to the core.
- stall_count  out  $clog2(MAX_STALL+1)  current consecutive stall count.

Behaviour:
- Index = addr[$clog2(DEPTH_WORDS)+1:2]. Upper bits ignored, so addresses wrap modulo DEPTH_WORDS*4. addr[1:0] ignored.
- Storage is not reset; contents are undefined until written.
- Activity: active = ren || we || pending.
  - pending (LATENCY=1 only) = a read was accepted last cycle.
  - pending is always 0 for LATENCY=0.
- Stall logic:
  - stall = !reset && stall_req && active && (stall_count < MAX_STALL).
  - stall_count increments on each cycle with stall=1 and clears to 0 on any cycle with stall=0.
  - Consequence: at most MAX_STALL consecutive stall cycles, then at least one forced non-stall cycle.
  - stall_req with no activity is ignored.
- Accept: a request is accepted on a cycle where it is asserted and stall=0.
- Write:
  - On an accepted write, each lane i with wstrb[i]=1 updates byte i of mem[widx]; other lanes are preserved.
  - Writes presented during stall are not committed; the core re-presents them.
- LATENCY=0:
  - rdata = mem[ridx] when ren, otherwise 0.
  - Same-cycle write to the same index: rdata shows pre-write contents.
- LATENCY=1:
  - On an accepted read, rdata_reg <= mem[ridx], with read-first semantics on a same-index write.
  - rdata_reg holds its value on all other cycles, including all stall cycles.
  - resp_valid = 1 on the cycle after an accepted read; pending mirrors resp_valid.
- Reset values (cycle after reset high): stall_count=0, pending=0, resp_valid=0, rdata_reg=INIT_WORD, stall=0.
  - stall is forced to 0 while reset is high.
  - Storage is unaffected.
  - Reset mid-stall abandons the stall; no write commits on a cycle where reset is high.
- Simultaneous read and write to different indices: both complete in the same cycle, independently.

Optional Feature:
SVC_RV_MEM_MODEL_STALL_EN
- Defined: stall injection exactly as above.
- Undefined: stall tied to 0, stall_count tied to 0, stall_req ignored, counter/gating logic not elaborated. Every request is accepted on its first cycle.

Test Plan:
- LATENCY=1, reset held 2 cycles then released -> rdata=0x00000013, stall=0, resp_valid=0, stall_count=0.
- Write 0xDEADBEEF @0x08 wstrb=0xF, then 0x0000AA00 @0x08 wstrb=0x2, then read @0x08 -> one cycle later rdata=0xDEADAAEF, resp_valid=1.
- DEPTH_WORDS=32: write 0x12345678 @0x80, read @0x00 -> rdata=0x12345678 (wrap). Read @0x03 -> same word.
- STALL_EN, MAX_STALL=2, stall_req=1 and ren=1 continuously -> stall pattern 1,1,0,1,1,0; stall_count 1,2,0,... Rdata unchanged across stall cycles; updates only after the 0 cycles.
- stall_req=1, ren=we=0, no pending -> stall stays 0. Then we=1 with stall_req=1 for 2 cycles -> write not visible until the cycle after stall drops.
- Reset asserted on second stall cycle -> next cycle stall=0, stall_count=0, rdata=0x00000013. Earlier written data still readable.
